// File: rtl/param_up_down_counter.sv
// -----------------------------------------------------------------------------
// param_up_down_counter
//
// Modulo-MODULUS up/down counter with parallel load, terminal-count flag,
// one-cycle wrap pulse and a sticky error flag for out-of-range loads.
//
// Optional feature: define UDC_SAT_EN to add the `sat` input. With sat=1 the
// counter holds at its end value instead of wrapping. Without the macro the
// port and its logic are absent and the counter always wraps.
//
// Parameters
//   WIDTH    : counter width in bits (>= 2)
//   MODULUS  : count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports
//   clk      : clock, all state changes on rising edge
//   reset    : synchronous active-low reset (q, wrap, err -> 0)
//   en       : count enable
//   up       : direction, 1 = up, 0 = down
//   load     : parallel-load strobe (wins over en)
//   load_val : parallel-load value
//   sat      : saturate mode select (UDC_SAT_EN builds only)
//   q        : registered count
//   tc       : combinational terminal count for the current direction
//   wrap     : registered pulse, high for the cycle after a wrapping edge
//   err      : sticky flag, set by a load with load_val >= MODULUS
// -----------------------------------------------------------------------------
module param_up_down_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDC_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the range check.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_err;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_end;
    logic             w_sat_hold;
    logic             w_load_oor;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_count_q;

    assign w_at_max  = (r_q == MAXV);
    assign w_at_zero = (r_q == '0);
    // End of range in the current direction: next enabled step would wrap.
    assign w_end     = up ? w_at_max : w_at_zero;

`ifdef UDC_SAT_EN
    assign w_sat_hold = sat & w_end;
`else
    assign w_sat_hold = 1'b0;
`endif

    assign w_load_oor = ({1'b0, load_val} >= MOD_W);
    assign w_load_q   = w_load_oor ? MAXV : load_val;

    always_comb begin
        w_count_q = r_q;
        if (w_sat_hold) begin
            w_count_q = r_q;
        end else if (up) begin
            w_count_q = w_at_max ? '0 : (r_q + ONE);
        end else begin
            w_count_q = w_at_zero ? MAXV : (r_q - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_q;
            r_wrap <= 1'b0;
            if (w_load_oor) begin
                r_err <= 1'b1;
            end
        end else if (en) begin
            r_q    <= w_count_q;
            r_wrap <= w_end & ~w_sat_hold;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign q    = r_q;
    assign tc   = w_end;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule
